// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) types and pure helpers, used by the decoder and the future encoder.
// codeword bit i is Hamming position i+1: {d4,d3,d2,p3,d1,p2,p1}.
package hamming_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    typedef logic [CODE_W-1:0] codeword_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

    // Even-parity checks; a nonzero result is the 1-based position of a single flipped bit.
    function automatic syndrome_t calc_syndrome(input codeword_t cw);
        syndrome_t s;
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return s;
    endfunction

    function automatic data_t extract_data(input codeword_t cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator for a received Hamming(7,4) codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [SYN_W-1:0]  syndrome
);

    always_comb begin
        syndrome = calc_syndrome(codeword);
    end

endmodule

// File: rtl/hamming_decoder.sv
// Single-error-correcting Hamming(7,4) decoder with registered syndrome and data, 1-cycle latency.
module hamming_decoder
    import hamming_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] codeword,
    output logic [SYN_W-1:0]  syndrome,
    output logic [DATA_W-1:0] data
);

    syndrome_t syn_c;
    codeword_t flip_mask;
    codeword_t corrected;

    hamming_syndrome u_syndrome (
        .codeword (codeword),
        .syndrome (syn_c)
    );

    // Syndrome 0 matches no position, so a clean word passes through unchanged.
    always_comb begin
        flip_mask = '0;
        for (int unsigned i = 0; i < CODE_W; i++) begin
            flip_mask[i] = (syn_c == SYN_W'(i + 1));
        end
        corrected = codeword ^ flip_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndrome <= '0;
            data     <= '0;
        end else begin
            syndrome <= syn_c;
            data     <= extract_data(corrected);
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: reset, hand-computed vectors, full single-flip sweep, async reset.
module tb_hamming_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] codeword;
    logic [2:0] syndrome;
    logic [3:0] data;

    int unsigned n_checks;
    int unsigned n_pass;

    hamming_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .codeword (codeword),
        .syndrome (syndrome),
        .data     (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder written from the parity equations, independent of the RTL.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] cw;
        cw[2] = d[0];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[3] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

    task automatic apply(input logic [6:0] cw, input logic [2:0] exp_syn, input logic [3:0] exp_data,
                         input string tag);
        codeword = cw;
        @(posedge clk);
        #1;
        check({tag, "_syn"},  8'(syndrome), 8'(exp_syn));
        check({tag, "_data"}, 8'(data),     8'(exp_data));
    endtask

    initial begin
        logic [6:0] cw;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        codeword = 7'b1111111;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_syn",  8'(syndrome), 8'h00);
            check("rst_data", 8'(data),     8'h00);
        end
        rst_n = 1'b1;
        apply(7'b1111111, 3'd0, 4'b1111, "release");

        apply(7'b0011101, 3'd3, 4'b0010, "d1_err");
        apply(7'b0101100, 3'd1, 4'b0101, "p1_err_a");
        apply(7'b1010011, 3'd1, 4'b1010, "p1_err_b");
        apply(7'b0011001, 3'd0, 4'b0010, "clean_a");
        apply(7'b1111111, 3'd0, 4'b1111, "clean_f");
        apply(7'b0000000, 3'd0, 4'b0000, "clean_0");

        // Input change between edges must not reach the outputs early.
        apply(7'b0011101, 3'd3, 4'b0010, "hold_pre");
        codeword = 7'b1111111;
        #3;
        check("hold_syn",  8'(syndrome), 8'd3);
        check("hold_data", 8'(data),     8'h2);

        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                cw = encode(4'(d));
                if (f != 0) cw[f-1] = ~cw[f-1];
                apply(cw, 3'(f), 4'(d), $sformatf("sweep_d%0d_f%0d", d, f));
            end
        end

        // Outputs are 7/F here; reset between edges must clear them at once.
        #2;
        rst_n = 1'b0;
        codeword = 'x;
        #1;
        check("async_syn",  8'(syndrome), 8'h00);
        check("async_data", 8'(data),     8'h00);
        @(posedge clk);
        #1;
        check("async_hold_syn",  8'(syndrome), 8'h00);
        check("async_hold_data", 8'(data),     8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(7'b0011101, 3'd3, 4'b0010, "resume_a");
        apply(7'b1010011, 3'd1, 4'b1010, "resume_b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
